tryte_block_sched: RTL and testbench
====================================

Name: tryte_block_sched

Overview:
- Sequencer in front of the curl absorb path.
- Accepts a stream of ASCII trytes, one per beat, and converts each into three balanced trits in the curl 2-bit encoding.
- Packs the trits into full 243-trit absorb blocks and hands each block to the curl controller with a valid/ready handshake.
- Pads the final partial block of a message with zero trits, flags illegal characters, and tracks the block count per message.

Parameters:
- TRYTES, 81, trytes per absorb block (block width = 3*TRYTES trits).
- CNT_W, 16, width of the per-message block counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s_valid  in  1  input tryte valid
- s_ready  out  1  input tryte ready
- s_data  in  8  ASCII tryte character
- s_last  in  1  last tryte of message
- m_valid  out  1  block valid
- m_ready  in  1  block accepted by curl controller
- m_data  out  6*TRYTES  packed block; trit j at bits [2j+1:2j]
- m_last  out  1  block is final block of message
- blk_cnt  out  CNT_W  blocks emitted in current message
- err_invalid  out  1  sticky illegal-character flag
- clr_err  in  1  synchronous clear of err_invalid
- busy  out  1  message in progress (not IDLE)

Behaviour:
- Reset values (reset_n low, asynchronous): state=IDLE, buffer=0, tryte index=0, s_ready=0, m_valid=0, m_last=0, blk_cnt=0, err_invalid=0, busy=0.
- Trit encoding: +1=2'b01, 0=2'b00, -1=2'b11. 2'b10 is never produced.
- Tryte decode: '9'=0, 'A'..'M'=1..13, 'N'..'Z'=-13..-1. Value = t0+3*t1+9*t2 with balanced trits.
- Tryte k occupies trits 3k (t0), 3k+1 (t1), 3k+2 (t2).
- Any other code: store 0 trits and set err_invalid next cycle. err_invalid is cleared only by clr_err or reset. If clr_err and a new error coincide, the error wins.
- State machine IDLE/FILL/PAD/OUT:
  - IDLE: s_ready=1. A tryte accepted in IDLE behaves as the first FILL beat; blk_cnt is cleared at message start.
  - FILL: s_ready=1; one tryte per accepted beat, written at the index, index increments.
    - Accept at index TRYTES-1 -> OUT, m_last=s_last.
    - Accept with s_last at index < TRYTES-1 -> PAD.
  - PAD: exactly 1 cycle. s_ready=0. Positions >= index are already zero because the buffer is cleared on block start. Then -> OUT with m_last=1.
  - OUT: s_ready=0, m_valid=1. m_data/m_last are held stable until m_ready.
    - On handshake: blk_cnt+1 (wraps at 2^CNT_W), buffer cleared, index=0.
    - Next state: IDLE if m_last, else FILL.
- Latency:
  - Last tryte of a full block accepted at cycle N -> m_valid at N+1.
  - Partial block (via PAD) -> m_valid at N+2.
- No overlap: input is stalled for the whole of PAD and OUT.
- s_last on exactly the TRYTES-th tryte: direct to OUT with m_last=1; no extra all-zero block.
- busy=1 in FILL/PAD/OUT.
- blk_cnt holds its final value in IDLE until the next message's first tryte.
- Reset mid-message discards all buffered trytes and any pending block.

Test Plan:
- TRYTES=81. Send "A","Z","M","N","9" then s_last -> one block, m_last=1, and:
  - bits[29:0] = 000000_111111_010101_000011_000001 (tryte 0 is the least-significant group);
  - all higher bits 0;
  - m_valid 2 cycles after the last accept;
  - blk_cnt=1.
- Send 162 "M" trytes, s_last on the 162nd:
  - two blocks, each all-2'b01, m_last=0 then 1, no pad cycle;
  - blk_cnt=2.
- Hold m_ready=0 for 10 cycles during OUT -> m_data/m_valid stable, s_ready=0 throughout; block accepted on cycle 11.
- Send "a" (0x61) and "@" (0x40) among valid trytes:
  - those trit positions are 0;
  - err_invalid=1 and stays 1 across blocks;
  - clr_err pulse returns it to 0.
- Assert reset_n low mid-FILL at index 40 -> all outputs at reset values immediately. A fresh 3-tryte message then produces a clean block with blk_cnt=1.
- Random s_valid gaps and m_ready stalls, 1000 random-length messages -> decoded blocks match the reference model; 2'b10 never appears.

Source files
------------

// File: rtl/tryte_block_sched.sv
// Tryte-to-trit block sequencer feeding the curl absorb path.
// Decodes ASCII trytes into balanced trits, packs them into absorb blocks,
// zero-pads the final partial block of a message and hands blocks downstream.
module tryte_block_sched #(
  parameter int unsigned TRYTES = 81,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [7:0]            s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [6*TRYTES-1:0]   m_data,
  output logic                  m_last,
  output logic [CNT_W-1:0]      blk_cnt,
  output logic                  err_invalid,
  input  logic                  clr_err,
  output logic                  busy
);

  localparam int unsigned BLK_W = 6 * TRYTES;
  localparam int unsigned IDX_W = $clog2(TRYTES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [IDX_W-1:0] idx;
  logic [BLK_W-1:0] blk_buf;
  logic [6:0]       dec_c;
  logic             accept_c;
  logic             hs_c;
  logic             at_end_c;

  // Map one balanced trit value onto the curl 2-bit code.
  function automatic logic [1:0] enc_trit(input int t);
    logic [1:0] r;
    case (t)
      1:       r = 2'b01;
      -1:      r = 2'b11;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Decode an ASCII tryte into {legal, t2, t1, t0}; illegal codes give zero trits.
  function automatic logic [6:0] decode_tryte(input logic [7:0] c);
    int         v;
    int         r;
    logic [5:0] tr;
    logic       ok;
    ok = 1'b1;
    v  = 0;
    tr = '0;
    if (c == 8'h39) begin
      v = 0;
    end else if (c >= 8'h41 && c <= 8'h4D) begin
      v = int'(c) - 64;
    end else if (c >= 8'h4E && c <= 8'h5A) begin
      v = int'(c) - 91;
    end else begin
      ok = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      r = v % 3;
      if (r > 1) begin
        r = r - 3;
      end else if (r < -1) begin
        r = r + 3;
      end
      tr[2*k +: 2] = enc_trit(r);
      v = (v - r) / 3;
    end
    return {ok, tr};
  endfunction

  assign dec_c    = decode_tryte(s_data);
  assign accept_c = s_valid & s_ready;
  assign hs_c     = m_valid & m_ready;
  assign at_end_c = (idx == IDX_W'(TRYTES - 1));
  assign m_data   = blk_buf;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE and FILL both take trytes; PAD is a single bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_FILL: begin
        if (accept_c) begin
          if (at_end_c) begin
            state_nxt = ST_OUT;
          end else if (s_last) begin
            state_nxt = ST_PAD;
          end else begin
            state_nxt = ST_FILL;
          end
        end
      end
      ST_PAD: begin
        state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (hs_c) begin
          state_nxt = m_last ? ST_IDLE : ST_FILL;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake and status outputs, registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      s_ready <= (state_nxt == ST_IDLE) || (state_nxt == ST_FILL);
      m_valid <= (state_nxt == ST_OUT);
      busy    <= (state_nxt != ST_IDLE);
    end
  end

  // Final-block flag: decided at the block-completing beat or in PAD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_last <= 1'b0;
    end else if (hs_c) begin
      m_last <= 1'b0;
    end else if (state == ST_PAD) begin
      m_last <= 1'b1;
    end else if (accept_c && at_end_c) begin
      m_last <= s_last;
    end
  end

  // Tryte write index within the current block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (hs_c) begin
      idx <= '0;
    end else if (accept_c) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // Block buffer; cleared on hand-off so unfilled positions read as zero trits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_buf <= '0;
    end else if (hs_c) begin
      blk_buf <= '0;
    end else if (accept_c) begin
      for (int k = 0; k < TRYTES; k++) begin
        if (idx == IDX_W'(k)) begin
          blk_buf[6*k +: 6] <= dec_c[5:0];
        end
      end
    end
  end

  // Per-message block counter: cleared by the first tryte of a message.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_cnt <= '0;
    end else if (accept_c && (state == ST_IDLE)) begin
      blk_cnt <= '0;
    end else if (hs_c) begin
      blk_cnt <= blk_cnt + CNT_W'(1);
    end
  end

  // Sticky illegal-character flag; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_invalid <= 1'b0;
    end else if (accept_c && !dec_c[6]) begin
      err_invalid <= 1'b1;
    end else if (clr_err) begin
      err_invalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tryte_block_sched.sv
// Directed and randomized bench for tryte_block_sched.
module tb_tryte_block_sched;

  localparam int unsigned TRYTES = 81;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BW     = 6 * TRYTES;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [7:0]       s_data = 8'h00;
  logic             s_last = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [BW-1:0]    m_data;
  logic             m_last;
  logic [CNT_W-1:0] blk_cnt;
  logic             err_invalid;
  logic             clr_err = 1'b0;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] got_data[$];
  logic          got_last[$];
  logic [BW-1:0] exp_data[$];
  logic          exp_last[$];
  logic [7:0]    msg_q[$];
  logic          saw_10 = 1'b0;
  logic          rnd_on = 1'b0;

  tryte_block_sched #(.TRYTES(TRYTES), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .blk_cnt     (blk_cnt),
    .err_invalid (err_invalid),
    .clr_err     (clr_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Capture every block that will be handed off at the next rising edge.
  always @(negedge clk) begin
    if (reset_n && m_valid && m_ready) begin
      got_data.push_back(m_data);
      got_last.push_back(m_last);
      for (int k = 0; k < 3 * TRYTES; k++) begin
        if (m_data[2*k +: 2] == 2'b10) saw_10 = 1'b1;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] tb_trit(input int t);
    if (t == 1) return 2'b01;
    if (t == -1) return 2'b11;
    return 2'b00;
  endfunction

  // Reference encoding by exhaustive search over the 27 balanced trit triples.
  function automatic logic [5:0] tb_enc(input logic [7:0] c);
    int         ci;
    int         v;
    logic [5:0] r;
    ci = int'(c);
    r  = 6'b0;
    if (ci == 57) v = 0;
    else if (ci >= 65 && ci <= 77) v = ci - 65 + 1;
    else if (ci >= 78 && ci <= 90) v = ci - 78 - 13;
    else return 6'b0;
    for (int a = -1; a <= 1; a++)
      for (int b = -1; b <= 1; b++)
        for (int d = -1; d <= 1; d++)
          if (a + 3 * b + 9 * d == v) r = {tb_trit(d), tb_trit(b), tb_trit(a)};
    return r;
  endfunction

  task automatic model_msg(output int nb);
    logic [BW-1:0] blk;
    int            k;
    blk = '0;
    k   = 0;
    nb  = 0;
    for (int i = 0; i < msg_q.size(); i++) begin
      blk[6*k +: 6] = tb_enc(msg_q[i]);
      k++;
      if (k == TRYTES) begin
        exp_data.push_back(blk);
        exp_last.push_back(i == msg_q.size() - 1);
        nb++;
        blk = '0;
        k   = 0;
      end
    end
    if (k != 0) begin
      exp_data.push_back(blk);
      exp_last.push_back(1'b1);
      nb++;
    end
  endtask

  task automatic send_tryte(input logic [7:0] c, input logic last, output bit to);
    int n;
    bit took;
    n = 0;
    s_valid = 1'b1;
    s_data  = c;
    s_last  = last;
    do begin
      took = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!took && n < 2000);
    s_valid = 1'b0;
    s_last  = 1'b0;
    to = !took;
  endtask

  task automatic send_msg(input bit gaps);
    bit to;
    int nto;
    nto = 0;
    for (int i = 0; i < msg_q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      send_tryte(msg_q[i], i == msg_q.size() - 1, to);
      if (to) nto++;
    end
    chk("send_timeout", 32'(nto), 32'd0);
  endtask

  task automatic compare_blocks(input string tag);
    int n;
    n = 0;
    while (got_data.size() < exp_data.size() && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_count"}, 32'(got_data.size()), 32'(exp_data.size()));
    while (exp_data.size() > 0 && got_data.size() > 0) begin
      chkd({tag, "_data"}, got_data.pop_front(), exp_data.pop_front());
      chk({tag, "_last"}, 32'(got_last.pop_front()), 32'(exp_last.pop_front()));
    end
    exp_data.delete();
    exp_last.delete();
    got_data.delete();
    got_last.delete();
  endtask

  task automatic fill_msg(input logic [7:0] c, input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(c);
  endtask

  initial begin
    logic [BW-1:0] exp_blk;
    logic [29:0]   lo;
    int            nb;
    int            bad;
    int            len;
    bit            to;
    logic [7:0]    c;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
    chk("rst_err", 32'(err_invalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chkd("rst_m_data", m_data, '0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_s_ready", 32'(s_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Partial block "AZMN9" with a held-off consumer
    m_ready = 1'b0;
    send_tryte("A", 1'b0, to);
    chk("p_busy", 32'(busy), 32'd1);
    send_tryte("Z", 1'b0, to);
    send_tryte("M", 1'b0, to);
    send_tryte("N", 1'b0, to);
    send_tryte("9", 1'b1, to);
    chk("pad_m_valid", 32'(m_valid), 32'd0);
    chk("pad_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    lo      = 30'b000000_111111_010101_000011_000001;
    exp_blk = BW'(lo);
    chk("p_m_valid", 32'(m_valid), 32'd1);
    chk("p_m_last", 32'(m_last), 32'd1);
    chkd("p_m_data", m_data, exp_blk);
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== exp_blk || m_last !== 1'b1) bad++;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("p_done_valid", 32'(m_valid), 32'd0);
    chk("p_blk_cnt", 32'(blk_cnt), 32'd1);
    chk("p_done_busy", 32'(busy), 32'd0);
    chk("p_got_one", 32'(got_data.size()), 32'd1);
    got_data.delete();
    got_last.delete();

    // 162 x "M": two full blocks, no pad bubble
    fill_msg("M", 162);
    model_msg(nb);
    send_msg(1'b0);
    chk("m162_direct_out", 32'(m_valid), 32'd1);
    compare_blocks("m162");
    chk("m162_blk_cnt", 32'(blk_cnt), 32'd2);

    // Exactly one full block with s_last on the last tryte
    fill_msg("Z", TRYTES);
    model_msg(nb);
    send_msg(1'b0);
    chk("z81_direct_out", 32'(m_valid), 32'd1);
    chk("z81_m_last", 32'(m_last), 32'd1);
    compare_blocks("z81");
    chk("z81_blk_cnt", 32'(blk_cnt), 32'd1);
    chk("pre_err", 32'(err_invalid), 32'd0);

    // Illegal characters inside a message
    msg_q.delete();
    msg_q.push_back("A");
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h40);
    msg_q.push_back("M");
    model_msg(nb);
    send_msg(1'b0);
    compare_blocks("bad");
    chk("err_set", 32'(err_invalid), 32'd1);
    fill_msg("B", 2);
    model_msg(nb);
    send_msg(1'b0);
    compare_blocks("after_bad");
    chk("err_sticky", 32'(err_invalid), 32'd1);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    chk("err_clr", 32'(err_invalid), 32'd0);
    clr_err = 1'b1;
    fill_msg(8'h40, 1);
    model_msg(nb);
    send_msg(1'b0);
    clr_err = 1'b0;
    chk("err_wins", 32'(err_invalid), 32'd1);
    compare_blocks("err_wins");

    // Reset in the middle of a block at index 40
    for (int i = 0; i < 40; i++) send_tryte("B", 1'b0, to);
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mr_s_ready", 32'(s_ready), 32'd0);
    chk("mr_m_valid", 32'(m_valid), 32'd0);
    chk("mr_blk_cnt", 32'(blk_cnt), 32'd0);
    chk("mr_err", 32'(err_invalid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chkd("mr_m_data", m_data, '0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    msg_q.delete();
    msg_q.push_back("A");
    msg_q.push_back("B");
    msg_q.push_back("C");
    model_msg(nb);
    send_msg(1'b0);
    compare_blocks("fresh");
    chk("fresh_blk_cnt", 32'(blk_cnt), 32'd1);

    // Random messages with input gaps and consumer stalls
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int m = 0; m < 1000; m++) begin
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(70, 170)) : int'($urandom_range(1, 12));
      msg_q.delete();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 39) == 0) begin
          c = 8'h61;
        end else begin
          nb = int'($urandom_range(0, 26));
          c  = (nb == 0) ? 8'h39 : 8'h40 + 8'(nb);
        end
        msg_q.push_back(c);
      end
      model_msg(nb);
      send_msg(1'b1);
      compare_blocks("rnd");
      chk("rnd_blk_cnt", 32'(blk_cnt), 32'(nb));
    end
    rnd_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_ready = 1'b1;
    chk("no_code_10", 32'(saw_10), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
